rosc_odometer_meas: RTL and testbench
=====================================

ROSC_ODOMETER_MEAS -- requirements
Module: rosc_odometer_meas

Interface
REQ-001 Parameter N_CH, default 4: ring-oscillator channel count; channel 0 is the unstressed reference; legal range 2..16.
REQ-002 Parameter CNT_W, default 16: edge-counter width.
REQ-003 Parameter WIN_W, default 16: gate-window length width.
REQ-004 Parameter SETTLE_CYC, default 8: oscillator start-up cycles discarded before counting; legal range 1 to 255.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 START  input  1  measurement request, sampled only in IDLE.
REQ-008 CH_SEL  input  clog2(N_CH)  channel under test, latched on accepted START.
REQ-009 MODE  input  1  0 = single count, 1 = differential against channel 0; latched on accepted START.
REQ-010 WINDOW  input  WIN_W  gate length in CLK cycles, latched on accepted START.
REQ-011 STRESS  input  1  ageing request: enables stressed channels while idle.
REQ-012 ROSC_IN  input  N_CH  asynchronous oscillator outputs, one bit per channel.
REQ-013 ROSC_EN  output  N_CH  oscillator enables, registered.
REQ-014 BUSY  output  1  high from accepted START until the DONE cycle, inclusive.
REQ-015 DONE  output  1  one-cycle pulse; result outputs valid from this cycle.
REQ-016 COUNT  output  CNT_W  rising edges of the selected channel in the window.
REQ-017 REF_COUNT  output  CNT_W  rising edges of channel 0 in the window; 0 when MODE=0.
REQ-018 DIFF  output  CNT_W+1  signed REF_COUNT minus COUNT; 0 when MODE=0.
REQ-019 OVF  output  1  either counter saturated during the last measurement.

Function
REQ-020 Each ROSC_IN bit SHALL pass a 2-flop synchroniser plus a third flop for rising-edge detection; the oscillator frequency is required to be below CLK/4.
REQ-021 FSM states SHALL be IDLE, SETTLE, COUNT, DONE.
REQ-022 IDLE->SETTLE on START=1; CH_SEL, MODE, WINDOW latched on that edge; START in any other state SHALL be ignored.
REQ-023 SETTLE SHALL last exactly SETTLE_CYC cycles; edges are discarded and counters held at 0.
REQ-024 COUNT SHALL last exactly WINDOW cycles; each detected edge increments its counter by 1.
REQ-025 WINDOW=0 SHALL go SETTLE->DONE directly, with COUNT=REF_COUNT=DIFF=0.
REQ-026 Timing, with START accepted at edge t: SETTLE covers t+1..t+SETTLE_CYC, COUNT covers the next WINDOW cycles, and DONE=1 on cycle t+SETTLE_CYC+WINDOW+1.
REQ-027 In DONE, COUNT, REF_COUNT, DIFF and OVF SHALL update in the same cycle as DONE=1; the FSM returns to IDLE on the next cycle.
REQ-028 Result outputs SHALL hold their values until the next DONE or RST.
REQ-029 Counters SHALL saturate at 2^CNT_W-1, with no wrap; OVF=1 if either counter saturates.
REQ-030 DIFF SHALL be computed sign-extended to CNT_W+1 bits; a negative result is legal.
REQ-031 CH_SEL>=N_CH SHALL enable no test channel and yield COUNT=0; MODE=1 with CH_SEL=0 SHALL yield COUNT=REF_COUNT and DIFF=0.
REQ-032 ROSC_EN in SETTLE and COUNT: bit CH_SEL set, plus bit 0 if MODE=1; all other bits 0.
REQ-033 ROSC_EN in IDLE: bits 1..N_CH-1 equal STRESS, and bit 0 is always 0.
REQ-034 ROSC_EN in DONE: all bits 0.
REQ-035 STRESS SHALL have no effect outside IDLE.

Reset
REQ-036 RST=1 SHALL force IDLE and clear all synchroniser flops, counters and latched fields; ROSC_EN, BUSY, DONE, COUNT, REF_COUNT, DIFF and OVF are all 0.
REQ-037 RST asserted mid-measurement SHALL abort the measurement without a DONE pulse, and results read 0 after reset.
REQ-038 RST SHALL take priority over START in the same cycle.

Verification
REQ-039 N_CH=4, MODE=0, CH_SEL=2, WINDOW=100, ch2 toggling at CLK/8 -> DONE at t+109, COUNT=12 or 13, REF_COUNT=0, DIFF=0, ROSC_EN=4'b0100 during measurement.
REQ-040 MODE=1, CH_SEL=3, ch0 at CLK/8, ch3 at CLK/10, WINDOW=400 -> REF_COUNT=50+/-1, COUNT=40+/-1, DIFF=10+/-2.
REQ-041 CNT_W=4, WINDOW=200, ch1 at CLK/8 -> COUNT=15, OVF=1; a second run with WINDOW=40 -> OVF=0.
REQ-042 WINDOW=0 -> DONE at t+SETTLE_CYC+1 with all results 0; START re-pulsed while BUSY -> ignored, exactly one DONE.
REQ-043 STRESS=1 in IDLE -> ROSC_EN=4'b1110; START accepted -> ROSC_EN follows REQ-032 from t+1.
REQ-044 RST pulsed in mid-COUNT -> no DONE, all outputs 0 on the next cycle, and a new START completes normally.

Source files
------------

// File: rtl/rosc_odometer_meas.sv
// Ring-oscillator odometer: gates edge counts of a selected oscillator (and
// optionally the unstressed reference) over a programmable window.
//
// state  | meaning
// IDLE   | waiting for START; stressed channels follow STRESS
// SETTLE | oscillators enabled, start-up edges discarded
// COUNT  | window open, edges counted
// DONE   | results published, one cycle
module rosc_odometer_meas #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [SEL_W-1:0]   CH_SEL,
  input  logic               MODE,
  input  logic [WIN_W-1:0]   WINDOW,
  input  logic               STRESS,
  input  logic [N_CH-1:0]    ROSC_IN,
  output logic [N_CH-1:0]    ROSC_EN,
  output logic               BUSY,
  output logic               DONE,
  output logic [CNT_W-1:0]   COUNT,
  output logic [CNT_W-1:0]   REF_COUNT,
  output logic [CNT_W:0]     DIFF,
  output logic               OVF
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [SEL_W-1:0]  ch_sel_q, ch_sel_d;
  logic              mode_q, mode_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  tmr_q, tmr_d;
  logic [7:0]        settle_q, settle_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, ref_q, ref_d;
  logic [CNT_W-1:0]  count_q, count_d, ref_count_q, ref_count_d;
  logic [CNT_W:0]    diff_q, diff_d;
  logic              ovf_q, ovf_d;
  logic [N_CH-1:0]   rosc_en_q, rosc_en_d;
  logic [N_CH-1:0]   edge_det;
  logic              sel_edge;

  assign edge_det = sync2_q & ~sync3_q;

  always_comb begin
    sel_edge = 1'b0;
    if (int'(ch_sel_q) < N_CH) sel_edge = edge_det[ch_sel_q];
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = ROSC_IN;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    ch_sel_d    = ch_sel_q;
    mode_d      = mode_q;
    win_d       = win_q;
    tmr_d       = tmr_q;
    settle_d    = settle_q;
    cnt_d       = cnt_q;
    ref_d       = ref_q;
    count_d     = count_q;
    ref_count_d = ref_count_q;
    diff_d      = diff_q;
    ovf_d       = ovf_q;
    rosc_en_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          ch_sel_d = CH_SEL;
          mode_d   = MODE;
          win_d    = WINDOW;
          settle_d = 8'(SETTLE_CYC - 1);
          cnt_d    = '0;
          ref_d    = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = '0;
        ref_d = '0;
        if (settle_q == 8'd0) begin
          if (win_q == '0) begin
            state_d = S_DONE;
          end else begin
            tmr_d   = win_q - 1'b1;
            state_d = S_COUNT;
          end
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_COUNT: begin
        // counters stick at all-ones instead of wrapping
        if (sel_edge && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
        if (mode_q && edge_det[0] && !(&ref_q)) ref_d = ref_q + 1'b1;
        if (tmr_q == '0) state_d = S_DONE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // results are captured from the final counter values so they appear with DONE
    if (state_d == S_DONE && state_q != S_DONE) begin
      count_d     = cnt_d;
      ref_count_d = ref_d;
      diff_d      = mode_q ? ({1'b0, ref_d} - {1'b0, cnt_d}) : '0;
      ovf_d       = (&cnt_d) | (&ref_d);
    end

    case (state_d)
      S_IDLE: rosc_en_d = {{(N_CH-1){STRESS}}, 1'b0};
      S_SETTLE, S_COUNT: begin
        for (int i = 0; i < N_CH; i++)
          rosc_en_d[i] = (int'(ch_sel_d) == i) || (i == 0 && mode_d);
      end
      default: rosc_en_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      ch_sel_q    <= '0;
      mode_q      <= 1'b0;
      win_q       <= '0;
      tmr_q       <= '0;
      settle_q    <= '0;
      cnt_q       <= '0;
      ref_q       <= '0;
      count_q     <= '0;
      ref_count_q <= '0;
      diff_q      <= '0;
      ovf_q       <= 1'b0;
      rosc_en_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      ch_sel_q    <= ch_sel_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      tmr_q       <= tmr_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      count_q     <= count_d;
      ref_count_q <= ref_count_d;
      diff_q      <= diff_d;
      ovf_q       <= ovf_d;
      rosc_en_q   <= rosc_en_d;
    end
  end

  assign ROSC_EN   = rosc_en_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_DONE);
  assign COUNT     = count_q;
  assign REF_COUNT = ref_count_q;
  assign DIFF      = diff_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_rosc_odometer_meas.sv
// Bench for rosc_odometer_meas: directed table, hand sequences and random runs
// checked against a timestamp-based edge-count model.
module tb_rosc_odometer_meas;
  localparam int S = 8;

  logic        CLK = 1'b0;
  logic        RST, START, MODE, STRESS;
  logic [1:0]  CH_SEL;
  logic [15:0] WINDOW;
  logic [3:0]  ROSC_IN = '0;

  logic [3:0]  en1, en2;
  logic        busy1, done1, ovf1, busy2, done2, ovf2;
  logic [15:0] cnt1, ref1;
  logic [16:0] diff1;
  logic [3:0]  cnt2, ref2;
  logic [4:0]  diff2;

  rosc_odometer_meas #(.N_CH(4), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CH_SEL(CH_SEL), .MODE(MODE),
    .WINDOW(WINDOW), .STRESS(STRESS), .ROSC_IN(ROSC_IN), .ROSC_EN(en1),
    .BUSY(busy1), .DONE(done1), .COUNT(cnt1), .REF_COUNT(ref1), .DIFF(diff1),
    .OVF(ovf1));

  rosc_odometer_meas #(.N_CH(4), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(S)) dut_narrow (
    .CLK(CLK), .RST(RST), .START(START), .CH_SEL(CH_SEL), .MODE(MODE),
    .WINDOW(WINDOW), .STRESS(STRESS), .ROSC_IN(ROSC_IN), .ROSC_EN(en2),
    .BUSY(busy2), .DONE(done2), .COUNT(cnt2), .REF_COUNT(ref2), .DIFF(diff2),
    .OVF(ovf2));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // oscillator models: toggle every half[i] clocks; record the index of the
  // first rising CLK edge that sees each new high level
  typedef struct { int ch; int p; } rise_t;
  rise_t rise_q[$];
  int half[4] = '{0, 0, 0, 0};
  int octr[4] = '{0, 0, 0, 0};

  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (half[i] != 0) begin
        octr[i]++;
        if (octr[i] >= half[i]) begin
          octr[i] = 0;
          ROSC_IN[i] = ~ROSC_IN[i];
          if (ROSC_IN[i]) rise_q.push_back('{i, cyc + 1});
        end
      end else begin
        ROSC_IN[i] = 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // edges sampled into the synchroniser at CLK edge p land in the window when
  // p+2 falls on one of the W counting edges, i.e. t+S+1 .. t+S+W
  function automatic int model_cnt(input int ch, input int lo, input int hi);
    int n = 0;
    foreach (rise_q[k])
      if (rise_q[k].ch == ch && rise_q[k].p >= lo && rise_q[k].p <= hi) n++;
    return n;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic run_meas(input bit mode, input int ch, input int win, input bit stress,
                          input bit repulse, output int lat);
    int t, ndone, lo, hi, ec, er, ec2, er2;
    bit en_bad, done_bad, idle_bad;
    logic [3:0] exp_en, idle_en;
    @(negedge CLK);
    START = 1'b1; MODE = mode; CH_SEL = 2'(ch); WINDOW = 16'(win); STRESS = stress;
    t = cyc + 1;
    rise_q.delete();
    exp_en  = 4'(1 << ch) | {3'b000, mode};
    idle_en = stress ? 4'b1110 : 4'b0000;
    @(negedge CLK);
    START = 1'b0; MODE = ~mode; CH_SEL = ~CH_SEL; WINDOW = ~WINDOW; STRESS = ~stress;
    lat = -1; ndone = 0; en_bad = 0; done_bad = 0; idle_bad = 0;
    for (int k = 0; k < S + win + 4; k++) begin
      if (done1) begin
        ndone++;
        if (lat < 0) lat = cyc - t + 1;
      end
      if (cyc < t + S + win) begin
        if (en1 !== exp_en || busy1 !== 1'b1) en_bad = 1;
        if (done1 !== 1'b0) done_bad = 1;
      end else if (cyc == t + S + win) begin
        if (en1 !== 4'b0000 || busy1 !== 1'b1) en_bad = 1;
        STRESS = stress;
      end else if (cyc == t + S + win + 1) begin
        if (en1 !== idle_en || busy1 !== 1'b0) idle_bad = 1;
      end
      START = (repulse && cyc == t + S + win / 2) ? 1'b1 : 1'b0;
      @(negedge CLK);
    end
    START = 1'b0;
    chk("done_latency", lat, S + win + 1);
    chk("done_pulses", ndone, 1);
    chk("en_busy_during_meas", en_bad, 0);
    chk("early_done", done_bad, 0);
    chk("idle_after_done", idle_bad, 0);
    lo = t + S - 1;
    hi = t + S + win - 2;
    ec = model_cnt(ch, lo, hi);
    er = mode ? model_cnt(0, lo, hi) : 0;
    ec2 = sat(ec, 15); er2 = sat(er, 15);
    ec  = sat(ec, 65535); er = sat(er, 65535);
    chk("count", cnt1, ec);
    chk("ref_count", ref1, er);
    chk("diff", longint'($signed(diff1)), mode ? er - ec : 0);
    chk("ovf", ovf1, (ec == 65535 || er == 65535) ? 1 : 0);
    chk("count_w4", cnt2, ec2);
    chk("ref_count_w4", ref2, er2);
    chk("diff_w4", longint'($signed(diff2)), mode ? er2 - ec2 : 0);
    chk("ovf_w4", ovf2, (ec2 == 15 || er2 == 15) ? 1 : 0);
  endtask

  typedef struct {
    bit mode; int ch; int win; int h0, h1, h2, h3; bit stress;
    int exp_lat; int cnt_lo, cnt_hi, ref_lo, ref_hi, diff_lo, diff_hi; bit exp_ovf2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    bit rst_bad, done_seen;
    vecs[0] = '{0, 2, 100, 0, 0, 4, 0, 0, 109, 12, 13,  0,  0,  0,  0, 0};
    vecs[1] = '{1, 3, 400, 4, 0, 0, 5, 1, 409, 39, 41, 49, 51,  8, 12, 1};
    vecs[2] = '{0, 1, 200, 0, 4, 0, 0, 0, 209, 24, 26,  0,  0,  0,  0, 1};
    vecs[3] = '{0, 1,  40, 0, 4, 0, 0, 1,  49,  4,  6,  0,  0,  0,  0, 0};
    vecs[4] = '{1, 2,   0, 4, 0, 4, 0, 0,   9,  0,  0,  0,  0,  0,  0, 0};
    vecs[5] = '{1, 0,  60, 3, 0, 0, 0, 0,  69,  9, 11,  9, 11,  0,  0, 0};

    RST = 1'b1; START = 1'b0; MODE = 1'b0; CH_SEL = '0; WINDOW = '0; STRESS = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_en", en1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_ovf", ovf1, 0);
    RST = 1'b0;
    STRESS = 1'b1;
    repeat (2) @(negedge CLK);
    chk("stress_idle_en", en1, 4'b1110);
    STRESS = 1'b0;
    repeat (2) @(negedge CLK);
    chk("nostress_idle_en", en1, 0);

    foreach (vecs[v]) begin
      half[0] = vecs[v].h0; half[1] = vecs[v].h1;
      half[2] = vecs[v].h2; half[3] = vecs[v].h3;
      repeat (12) @(negedge CLK);
      run_meas(vecs[v].mode, vecs[v].ch, vecs[v].win, vecs[v].stress, 1'b0, lat);
      chk($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      chk_rng($sformatf("vec%0d_count", v), cnt1, vecs[v].cnt_lo, vecs[v].cnt_hi);
      chk_rng($sformatf("vec%0d_ref", v), ref1, vecs[v].ref_lo, vecs[v].ref_hi);
      chk_rng($sformatf("vec%0d_diff", v), longint'($signed(diff1)), vecs[v].diff_lo, vecs[v].diff_hi);
      chk($sformatf("vec%0d_ovf_w4", v), ovf2, vecs[v].exp_ovf2);
    end

    // START re-pulsed while busy must be ignored
    half = '{4, 3, 5, 6};
    repeat (8) @(negedge CLK);
    run_meas(1'b1, 2, 50, 1'b1, 1'b1, lat);
    run_meas(1'b0, 1, 1, 1'b0, 1'b0, lat);

    // reset in the middle of a counting window
    run_meas(1'b1, 3, 30, 1'b0, 1'b0, lat);
    @(negedge CLK);
    START = 1'b1; MODE = 1'b1; CH_SEL = 2'd3; WINDOW = 16'd200; STRESS = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    repeat (S + 20) @(negedge CLK);
    RST = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    chk("midrst_en", en1, 0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    chk("midrst_count", cnt1, 0);
    chk("midrst_ref", ref1, 0);
    chk("midrst_diff", diff1, 0);
    chk("midrst_ovf", ovf1, 0);
    RST = 1'b0;
    START = 1'b0;
    done_seen = 0; rst_bad = 0;
    for (int k = 0; k < 250; k++) begin
      if (done1) done_seen = 1;
      if (busy1 !== 1'b0) rst_bad = 1;
      @(negedge CLK);
    end
    chk("midrst_no_done", done_seen, 0);
    chk("midrst_stays_idle", rst_bad, 0);
    run_meas(1'b1, 3, 80, 1'b0, 1'b0, lat);

    for (int r = 0; r < 20; r++) begin
      int win;
      bit rp;
      for (int i = 0; i < 4; i++)
        half[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(3, 9));
      repeat (10) @(negedge CLK);
      win = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 250));
      rp = (win >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_meas(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), win,
               1'($urandom_range(0, 1)), rp, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
